// File: rtl/semaforo_pkg.sv
// Shared definitions for the nine-channel traffic-light driver:
// channel state encoding, channel indices and the default pedestrian map.
package semaforo_pkg;

    typedef enum logic [1:0] {
        ST_RED   = 2'd0,
        ST_GREEN = 2'd1,
        ST_CLEAR = 2'd2   // YELLOW on vehicle heads, BLINK_GREEN on pedestrian heads
    } ch_state_t;

    localparam int NUM_CH         = 9;
    localparam int CH_NN          = 0;
    localparam int CH_NS          = 1;
    localparam int CH_TH          = 2;
    localparam int CH_GIRO_NN_IZQ = 3;
    localparam int CH_GIRO_NN_DER = 4;
    localparam int CH_GIRO_TH_IZQ = 5;
    localparam int CH_PEA_N       = 6;
    localparam int CH_PEA_TH1     = 7;
    localparam int CH_PEA_TH2     = 8;

    localparam logic [NUM_CH-1:0] DEFAULT_PED_MASK = 9'b111000000;

    function automatic ch_state_t next_state(input ch_state_t s);
        case (s)
            ST_RED:   return ST_GREEN;
            ST_GREEN: return ST_CLEAR;
            default:  return ST_RED;
        endcase
    endfunction

endpackage

// File: rtl/semaforo_channel.sv
// One signal head: RED -> GREEN -> CLEAR -> RED state plus lamp decode.
// IS_PED selects pedestrian behaviour for CLEAR and for flashing mode.
module semaforo_channel
    import semaforo_pkg::*;
#(
    parameter bit IS_PED = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic load_green,
    input  logic advance,
    input  logic flash,
    input  logic blink_phase,
    output logic red,
    output logic yellow,
    output logic green,
    output logic is_red
);

    ch_state_t state;

    // NOTE: sequential state uses non-blocking assignments so every channel
    // samples the same pre-edge values regardless of evaluation order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_RED;
        end else if (load) begin
            state <= load_green ? ST_GREEN : ST_RED;
        end else if (advance) begin
            state <= next_state(state);
        end
    end

    assign is_red = (state == ST_RED);

    // NOTE: every lamp gets a default before the branches, so no latch is inferred.
    always_comb begin
        red    = 1'b0;
        yellow = 1'b0;
        green  = 1'b0;
        if (flash) begin
            if (IS_PED) red    = blink_phase;
            else        yellow = blink_phase;
        end else begin
            case (state)
                ST_RED:   red   = 1'b1;
                ST_GREEN: green = 1'b1;
                ST_CLEAR: begin
                    if (IS_PED) green  = blink_phase;
                    else        yellow = 1'b1;
                end
                default:  red   = 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/semaforo_driver.sv
// Nine-channel intersection driver: blink generator, enable edge load,
// sticky TH-versus-NN/NS conflict detector forcing flashing mode.
module semaforo_driver
    import semaforo_pkg::*;
#(
    parameter int                CLK_HZ     = 10000,
    parameter int                BLINK_HALF = 2500,
    parameter logic [NUM_CH-1:0] PED_MASK   = DEFAULT_PED_MASK
) (
    input  logic              CLK,
    input  logic              reset_general_n,
    input  logic              enable_general,
    input  logic [NUM_CH-1:0] change,
    input  logic [NUM_CH-1:0] set_val,
    output logic [NUM_CH-1:0] lamp_red,
    output logic [NUM_CH-1:0] lamp_yellow,
    output logic [NUM_CH-1:0] lamp_green,
    output logic [NUM_CH-1:0] red_status,
    output logic              red_check_SemaforoNN_E6,
    output logic              conflict
);

    // Counter is sized to hold a full second or the blink half-period, whichever is larger.
    localparam int CNT_MAX = (CLK_HZ > BLINK_HALF) ? CLK_HZ : BLINK_HALF;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_HALF - 1);

    logic [CNT_W-1:0] blink_cnt;
    logic             blink_phase;
    logic             en_q;
    logic             load;
    logic             flash;
    logic             unsafe;

    always_ff @(posedge CLK or negedge reset_general_n) begin
        if (!reset_general_n) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (blink_cnt == CNT_LAST) begin
            blink_cnt   <= '0;
            blink_phase <= ~blink_phase;
        end else begin
            blink_cnt   <= blink_cnt + 1'b1;
        end
    end

    // en_q resets low, so an enable held through reset still produces a load.
    assign load = enable_general & ~en_q;

    assign unsafe = ~red_status[CH_TH] & (~red_status[CH_NN] | ~red_status[CH_NS]);

    always_ff @(posedge CLK or negedge reset_general_n) begin
        if (!reset_general_n) begin
            en_q     <= 1'b0;
            conflict <= 1'b0;
        end else begin
            en_q <= enable_general;
            if (unsafe) conflict <= 1'b1;
        end
    end

    assign flash = ~enable_general | conflict;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        semaforo_channel #(
            .IS_PED (PED_MASK[i])
        ) u_channel (
            .clk         (CLK),
            .rst_n       (reset_general_n),
            .load        (load),
            .load_green  (set_val[i]),
            .advance     (enable_general & change[i]),
            .flash       (flash),
            .blink_phase (blink_phase),
            .red         (lamp_red[i]),
            .yellow      (lamp_yellow[i]),
            .green       (lamp_green[i]),
            .is_red      (red_status[i])
        );
    end

    assign red_check_SemaforoNN_E6 = red_status[CH_NN];

endmodule

// File: doc/semaforo_driver.md
SEMAFORO_DRIVER -- requirements
Module: semaforo_driver

Interface
REQ-001 The block SHALL take parameter CLK_HZ, default 10000, as the clock frequency in Hz.
REQ-002 The block SHALL take parameter BLINK_HALF, default 2500, as the blink half-period in cycles (2 Hz blink).
REQ-003 The block SHALL take parameter PED_MASK, default 9'b111000000, where bit=1 marks a pedestrian channel.
REQ-004 The block SHALL have port CLK, input, 1 bit: system clock (10 kHz); one clock; all state on rising edge.
REQ-005 The block SHALL have port reset_general_n, input, 1 bit: reset, asynchronous, active-low.
REQ-006 The block SHALL have port enable_general, input, 1 bit: 1 = normal operation, 0 = flashing mode.
REQ-007 The block SHALL have port change, input, 9 bits: one-cycle advance pulses; bit order [0]NN [1]NS [2]TH [3]Giro_NN_izq [4]Giro_NN_der [5]Giro_TH_izq [6]peaton_N [7]peaton_TH1 [8]peaton_TH2.
REQ-008 The block SHALL have port set_val, input, 9 bits: initial lamp per channel (1 = GREEN, 0 = RED).
REQ-009 The block SHALL have port lamp_red, lamp_yellow, lamp_green, outputs, 9 bits each: lamp drive per channel.
REQ-010 The block SHALL have port red_status, output, 9 bits: 1 when the channel state is RED.
REQ-011 The block SHALL have port red_check_SemaforoNN_E6, output, 1 bit: equal to red_status[0].
REQ-012 The block SHALL have port conflict, output, 1 bit: sticky conflict flag.

Function
REQ-013 Each channel SHALL hold a 2-bit state: RED, GREEN, or CLEAR (YELLOW for vehicle channels, BLINK_GREEN for pedestrian channels).
REQ-014 When change[i]=1 and the block is enabled, channel i SHALL advance RED->GREEN->CLEAR->RED on that clock edge, one step per pulse.
REQ-015 A change pulse held for N cycles SHALL advance the channel N steps; there is no edge detection.
REQ-016 The rising edge of enable_general, detected from a registered copy, SHALL load every channel from set_val (GREEN if 1, RED if 0) on the first enabled cycle.
REQ-017 On that load cycle, the load SHALL take priority over change.
REQ-018 While enable_general=0, change SHALL be ignored and channel states SHALL be held.
REQ-019 While enable_general=0, lamp outputs SHALL be: vehicle channels yellow = blink_phase, red = green = 0; pedestrian channels red = blink_phase, other lamps 0.
REQ-020 The blink counter SHALL count 0..BLINK_HALF-1 and wrap to 0; blink_phase SHALL toggle on wrap.
REQ-021 The blink counter SHALL run continuously regardless of enable_general.
REQ-022 Decode in normal mode SHALL be: RED -> red=1; GREEN -> green=1; vehicle CLEAR -> yellow=1; pedestrian CLEAR -> green = blink_phase.
REQ-023 Exactly one lamp per vehicle channel SHALL be lit in normal mode.
REQ-024 Lamp outputs and red_status SHALL be combinational from registered state, giving a change-to-lamp latency of 1 edge.
REQ-025 conflict SHALL be set when state TH != RED simultaneously with NN != RED or NS != RED, and SHALL remain set until reset.
REQ-026 While conflict=1, outputs SHALL follow flashing mode (REQ-019) regardless of enable_general, and channel states SHALL still update.
REQ-027 conflict SHALL register one edge after the offending state appears.

Reset
REQ-028 Asserting reset_general_n=0 SHALL immediately set: all channels RED, blink counter 0, blink_phase 0, conflict 0, enable register 0.
REQ-029 After deassertion, outputs SHALL be lamp_red=9'h1FF, others 0, red_status=9'h1FF (if enable_general=1), or flashing-mode values (if enable_general=0).
REQ-030 If enable_general is held at 1 through deassertion of reset, it SHALL count as a rising edge and trigger the set_val load.
REQ-031 Reset asserted mid-sequence SHALL abandon all state; there is no resume.

Structure
REQ-032 The shared package SHALL contain: the state encodings (RED=2'd0, GREEN=2'd1, CLEAR=2'd2), the channel index constants (CH_NN..CH_PEA_TH2), and the default PED_MASK.
REQ-033 Per-channel state plus decode SHALL be one sub-module, semaforo_channel (param IS_PED), instantiated 9 times.
REQ-034 The blink counter, enable edge detection, and conflict logic SHALL reside in the top module.

Verification
REQ-035 Scenario 1: reset, enable 0->1 with set_val=9'b101001011 -> next cycle lamp_green=9'b101001011, lamp_red=9'b010110100.
REQ-036 Scenario 2: NN GREEN, change[0] pulsed 2 cycles apart -> lamp_yellow[0]=1, then lamp_red[0]=1 and red_check_SemaforoNN_E6=1.
REQ-037 Scenario 3: peaton_N in CLEAR -> lamp_green[6] toggles every 2500 cycles; lamp_red[6]=0.
REQ-038 Scenario 4: enable_general=0 -> lamp_yellow[5:0] toggles every 2500 cycles; change pulses leave states unchanged after re-enable... except re-enable reloads set_val.
REQ-039 Scenario 5: NS and TH both driven to GREEN -> conflict=1 next edge; flashing output persists after enable; cleared only by reset_general_n=0.
REQ-040 Scenario 6: reset_general_n pulsed low mid-cycle (async, between edges) -> lamp_red=9'h1FF immediately, without waiting for CLK.
